// File: rtl/arm_imm_pkg.sv
// Shared types and field layout for the ARM operand-2 immediate encoder.
package arm_imm_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam int ROT_COUNT = 16;
  localparam int IMM8_W    = 8;

  // imm12 = {rot, imm8}
  localparam int ROT_MSB  = 11;
  localparam int ROT_LSB  = 8;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;
endpackage

// File: rtl/imm_rot_check.sv
// Checks whether one rotation of a 32-bit value fits an 8-bit immediate.
module imm_rot_check
  import arm_imm_pkg::*;
(
  input  logic [31:0]       val,
  input  logic [3:0]        rot,
  output logic              fits,
  output logic [IMM8_W-1:0] imm8
);
  logic [4:0]  sh;
  logic [31:0] v;

  // ROL by 2*rot undoes the decoder's ROR; shift by 32 yields 0 at rot 0
  assign sh   = {rot, 1'b0};
  assign v    = (val << sh) | (val >> (6'd32 - {1'b0, sh}));
  assign fits = (v[31:IMM8_W] == '0);
  assign imm8 = v[IMM8_W-1:0];
endmodule

// File: rtl/imm_encoder.sv
// Iterative immediate encoder: one rotation per cycle, lowest rot wins.
module imm_encoder
  import arm_imm_pkg::*;
#(
  parameter bit ALLOW_INVERT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        encodable,
  output logic        inverted,
  output logic [11:0] imm12
);
  state_t              state;
  logic [3:0]          rot;
  logic [31:0]         val_q;
  logic                plain_fits, inv_fits_raw, inv_fits;
  logic [IMM8_W-1:0]   plain_imm8, inv_imm8;

  imm_rot_check u_plain (.val(val_q),  .rot(rot), .fits(plain_fits),   .imm8(plain_imm8));
  imm_rot_check u_inv   (.val(~val_q), .rot(rot), .fits(inv_fits_raw), .imm8(inv_imm8));

  assign inv_fits = ALLOW_INVERT && inv_fits_raw;
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rot       <= '0;
      val_q     <= '0;
      out_valid <= 1'b0;
      encodable <= 1'b0;
      inverted  <= 1'b0;
      imm12     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          val_q <= value;
          rot   <= '0;
          state <= SEARCH;
        end
        SEARCH: begin
          // plain match has priority over the inverted one at the same rot
          if (plain_fits) begin
            encodable                 <= 1'b1;
            inverted                  <= 1'b0;
            imm12[ROT_MSB:ROT_LSB]    <= rot;
            imm12[IMM8_MSB:IMM8_LSB]  <= plain_imm8;
            out_valid                 <= 1'b1;
            state                     <= DONE;
          end else if (inv_fits) begin
            encodable                 <= 1'b1;
            inverted                  <= 1'b1;
            imm12[ROT_MSB:ROT_LSB]    <= rot;
            imm12[IMM8_MSB:IMM8_LSB]  <= inv_imm8;
            out_valid                 <= 1'b1;
            state                     <= DONE;
          end else if (rot == 4'(ROT_COUNT - 1)) begin
            encodable <= 1'b0;
            inverted  <= 1'b0;
            imm12     <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rot <= rot + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: both ALLOW_INVERT settings, backpressure, mid-search reset.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid1;
  logic [31:0] value;
  logic        out_ready;
  logic        in_ready0, out_valid0, encodable0, inverted0;
  logic [11:0] imm12_0;
  logic        in_ready1, out_valid1, encodable1, inverted1;
  logic [11:0] imm12_1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_encoder #(.ALLOW_INVERT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .value(value),
    .out_valid(out_valid0), .out_ready(out_ready), .encodable(encodable0),
    .inverted(inverted0), .imm12(imm12_0));

  imm_encoder #(.ALLOW_INVERT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .value(value),
    .out_valid(out_valid1), .out_ready(out_ready), .encodable(encodable1),
    .inverted(inverted1), .imm12(imm12_1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one request to dut0 (sel=0) or dut1 (sel=1) with out_ready already high
  task automatic run(input bit sel, input logic [31:0] v, input logic e, input logic i,
                     input logic [11:0] imm, input int lat);
    int k;
    @(negedge clk);
    chk($sformatf("in_ready before %h", v), sel ? in_ready1 : in_ready0, 1);
    value = v;
    if (sel) in_valid1 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_valid1 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(sel ? out_valid1 : out_valid0) && k < 40);
    chk($sformatf("latency %h", v), k, lat);
    chk($sformatf("encodable %h", v), sel ? encodable1 : encodable0, e);
    chk($sformatf("inverted %h", v), sel ? inverted1 : inverted0, i);
    chk($sformatf("imm12 %h", v), sel ? imm12_1 : imm12_0, imm);
    @(negedge clk);
    chk($sformatf("out_valid drop %h", v), sel ? out_valid1 : out_valid0, 0);
    chk($sformatf("in_ready after %h", v), sel ? in_ready1 : in_ready0, 1);
  endtask

  initial begin
    int k, seen;
    rst = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0; value = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid0, 0);
    chk("reset encodable", encodable0, 0);
    chk("reset inverted", inverted0, 0);
    chk("reset imm12", imm12_0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", in_ready0, 1);

    run(0, 32'h000000FF, 1, 0, 12'h0FF, 2);
    run(0, 32'hFF000000, 1, 0, 12'h4FF, 6);
    run(0, 32'h000003FC, 1, 0, 12'hFFF, 17);
    run(0, 32'h00000101, 0, 0, 12'h000, 17);
    run(0, 32'hFFFFFF00, 1, 1, 12'h0FF, 2);
    run(1, 32'hFFFFFF00, 0, 0, 12'h000, 17);
    run(1, 32'hFF000000, 1, 0, 12'h4FF, 6);

    // backpressure: result held for 5 cycles with out_ready low
    out_ready = 1'b0;
    @(negedge clk);
    value = 32'h0000FF00; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!out_valid0 && k < 40);
    chk("bp latency", k, 14);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp out_valid c%0d", c), out_valid0, 1);
      chk($sformatf("bp imm12 c%0d", c), imm12_0, 12'hCFF);
      chk($sformatf("bp in_ready c%0d", c), in_ready0, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", out_valid0, 0);
    chk("bp release in_ready", in_ready0, 1);

    // reset while the search for 0x101 sits at rot 5
    @(negedge clk);
    value = 32'h00000101; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rot before reset", dut0.rot, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst out_valid", out_valid0, 0);
    chk("mid rst encodable", encodable0, 0);
    chk("mid rst inverted", inverted0, 0);
    chk("mid rst imm12", imm12_0, 0);
    chk("mid rst rot", dut0.rot, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid0) seen++; end
    chk("dropped request output", seen, 0);
    run(0, 32'h000000FF, 1, 0, 12'h0FF, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
